mem_responder: RTL and testbench

//   Memory-side responder for the Mini-SRC datapath's MAR/MDR interface.

---
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_responder.sv | 111 +++++++++++
 tb/tb_mem_responder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Initiator <-> mem_responder bus: strobes, address/data, read return and status.
// Err is present only when MEM_ERR_EN is defined.
interface mem_responder_if #(
  parameter int DATA_W = 32
);
  logic              Read;
  logic              Write;
  logic [31:0]       MAR_addr;
  logic [DATA_W-1:0] MDR_data;
  logic [DATA_W-1:0] Mdatain;
  logic              Done;
  logic              Busy;
`ifdef MEM_ERR_EN
  logic              Err;

  modport master (output Read, Write, MAR_addr, MDR_data,
                  input  Mdatain, Done, Busy, Err);
  modport slave  (input  Read, Write, MAR_addr, MDR_data,
                  output Mdatain, Done, Busy, Err);
`else
  modport master (output Read, Write, MAR_addr, MDR_data,
                  input  Mdatain, Done, Busy);
  modport slave  (input  Read, Write, MAR_addr, MDR_data,
                  output Mdatain, Done, Busy);
`endif
endinterface

// File: rtl/mem_responder.sv
// Word RAM responder for the MAR/MDR interface with programmable wait states and a one-cycle Done.
// Optional MEM_ERR_EN: out-of-range upper address bits raise Err and suppress the access.
module mem_responder #(
  parameter int ADDR_BITS   = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clock,
  input  logic            clear,
  mem_responder_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t               state, state_nx;
  logic [3:0]           cnt, cnt_nx;
  logic                 capture, perform;
  logic [ADDR_BITS-1:0] idx_q;
  logic [DATA_W-1:0]    data_q;
  logic                 rd_q;
  logic                 bad_d, bad_q;
  logic [DATA_W-1:0]    mdat_q;
  logic                 done_q, busy_q;
  logic [DATA_W-1:0]    mem [DEPTH];

`ifdef MEM_ERR_EN
  logic err_q;
  assign bad_d = |bus.MAR_addr[31:ADDR_BITS];
`else
  // Upper address bits alias silently in this build.
  logic unused_upper;
  assign unused_upper = ^bus.MAR_addr[31:ADDR_BITS];
  assign bad_d        = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    perform  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.Read || bus.Write) begin
          capture  = 1'b1;
          cnt_nx   = 4'(WAIT_CYCLES);
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
        end else begin
          perform  = 1'b1;
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state  <= IDLE;
      cnt    <= '0;
      idx_q  <= '0;
      data_q <= '0;
      rd_q   <= 1'b0;
      bad_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      done_q <= (state_nx == DONE);
      busy_q <= (state_nx != IDLE);
      if (capture) begin
        idx_q  <= bus.MAR_addr[ADDR_BITS-1:0];
        data_q <= bus.MDR_data;
        rd_q   <= bus.Read;
        bad_q  <= bad_d;
      end
    end
  end

  // NOTE: the array is deliberately not reset; a reset leaves its contents intact.
  // An async clear forces IDLE, so perform is low and an aborted write never lands.
  always_ff @(posedge clock) begin
    if (perform && !rd_q && !bad_q) mem[idx_q] <= data_q;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear)                mdat_q <= '0;
    else if (perform && rd_q) mdat_q <= bad_q ? '0 : mem[idx_q];
  end

`ifdef MEM_ERR_EN
  always_ff @(posedge clock or posedge clear) begin
    if (clear) err_q <= 1'b0;
    else       err_q <= (state_nx == DONE) && bad_q;
  end
  assign bus.Err = err_q;
`endif

  assign bus.Mdatain = mdat_q;
  assign bus.Done    = done_q;
  assign bus.Busy    = busy_q;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed cases, random traffic against a word-array model,
// and a wait-state sweep on two extra instances.
module tb_mem_responder;
  localparam int ADDR_BITS = 9;
  localparam int DATA_W    = 32;
  localparam int WAIT      = 2;

  typedef struct {
    bit          is_read;
    bit          err;
    logic [31:0] mdat;
    int          done_cyc;
  } exp_t;

  logic clock = 1'b0;
  logic clear;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  exp_t        sb [$];
  logic [31:0] ref_mem [int];
  int          wr_idx [$];
  logic [31:0] mdat_model = '0;
  bit          sweep_go = 1'b0;
  bit          sweep_done [2];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mem_responder_if #(.DATA_W(DATA_W)) bus ();

  mem_responder #(.ADDR_BITS(ADDR_BITS), .DATA_W(DATA_W), .WAIT_CYCLES(WAIT)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every Done pulse is matched against the oldest outstanding expectation.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (clear === 1'b0 && bus.Done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", bus.Done, 0);
      end else begin
        e = sb.pop_front();
        check("done_cycle", cyc, e.done_cyc);
        check("mdatain", bus.Mdatain, e.mdat);
        check("busy_at_done", bus.Busy, 1);
`ifdef MEM_ERR_EN
        check("err", bus.Err, e.err);
`endif
      end
    end
  end

  // Issue one request at a negedge, wait (bounded) for Done, then drop the strobes.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input bit poke);
    exp_t e;
    int   idx;
    bit   err;
    bit   got;
    idx = int'(a[ADDR_BITS-1:0]);
    err = 1'b0;
`ifdef MEM_ERR_EN
    err = (a[31:ADDR_BITS] != '0);
`endif
    if (rd) begin
      mdat_model = err ? 32'h0 : ref_mem[idx];
    end else if (wr && !err) begin
      ref_mem[idx] = d;
      wr_idx.push_back(idx);
    end
    e.is_read  = rd;
    e.err      = err;
    e.mdat     = mdat_model;
    e.done_cyc = cyc + 2 + WAIT;
    sb.push_back(e);
    bus.Read     = rd;
    bus.Write    = wr;
    bus.MAR_addr = a;
    bus.MDR_data = d;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      got = bus.Done;
      if (poke && i == 0) begin
        bus.Write    = 1'b1;
        bus.MAR_addr = a + 32'd1;
        bus.MDR_data = ~d;
      end
      if (poke && i == 1) begin
        bus.Write    = wr;
        bus.MAR_addr = a;
      end
    end
    if (!got) begin
      check("done_timeout", got, 1);
      sb.delete();
    end
    bus.Read  = 1'b0;
    bus.Write = 1'b0;
    @(negedge clock);
    check("done_one_cycle", bus.Done, 0);
    check("idle_not_busy", bus.Busy, 0);
  endtask

  // Wait-state sweep: separate instances with 0 and 7 wait cycles.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
    localparam int W = (gi == 0) ? 0 : 7;
    mem_responder_if #(.DATA_W(DATA_W)) sbus ();
    mem_responder #(.ADDR_BITS(ADDR_BITS), .DATA_W(DATA_W), .WAIT_CYCLES(W)) sdut (
      .clock (clock),
      .clear (clear),
      .bus   (sbus.slave)
    );
    initial begin
      logic [31:0] val;
      int          t;
      bit          got;
      sweep_done[gi] = 1'b0;
      sbus.Read = 1'b0; sbus.Write = 1'b0; sbus.MAR_addr = '0; sbus.MDR_data = '0;
      wait (sweep_go);
      val = $urandom();
      for (int op = 0; op < 2; op++) begin
        @(negedge clock);
        sbus.Read     = (op == 1);
        sbus.Write    = (op == 0);
        sbus.MAR_addr = 32'h7;
        sbus.MDR_data = val;
        got = 1'b0;
        t   = 0;
        while (!got && t < 40) begin
          @(negedge clock);
          t++;
          got = sbus.Done;
          if (!got) check("sweep_busy", sbus.Busy, 1);
        end
        check("sweep_latency", t, W + 2);
        if (op == 1) check("sweep_rdata", sbus.Mdatain, val);
        sbus.Read  = 1'b0;
        sbus.Write = 1'b0;
      end
      sweep_done[gi] = 1'b1;
    end
  end

  initial begin
    int n_done;
    clear = 1'b1;
    bus.Read = 1'b0; bus.Write = 1'b0; bus.MAR_addr = '0; bus.MDR_data = '0;
    repeat (3) @(negedge clock);
    check("reset_mdatain", bus.Mdatain, 0);
    check("reset_done", bus.Done, 0);
    check("reset_busy", bus.Busy, 0);
    clear = 1'b0;
    @(negedge clock);

    // Write then read back.
    issue(1'b0, 1'b1, 32'h05, 32'hDEADBEEF, 1'b0);
    issue(1'b1, 1'b0, 32'h05, 32'h0, 1'b0);

    // Read/Write collision: read wins, write is dropped; later Write pulse in ACCESS is ignored.
    issue(1'b0, 1'b1, 32'h10, 32'h1234, 1'b0);
    issue(1'b1, 1'b1, 32'h10, 32'hFFFF0000, 1'b0);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

    // Abort: clear mid-ACCESS of a write; old contents survive and Done never pulses.
    issue(1'b0, 1'b1, 32'h20, 32'h11112222, 1'b0);
    bus.Write = 1'b1; bus.MAR_addr = 32'h20; bus.MDR_data = 32'hAAAA5555;
    @(negedge clock);
    @(negedge clock);
    #2 clear = 1'b1;
    #1;
    check("async_reset_mdatain", bus.Mdatain, 0);
    check("async_reset_done", bus.Done, 0);
    check("async_reset_busy", bus.Busy, 0);
    bus.Write  = 1'b0;
    mdat_model = '0;
    @(negedge clock);
    clear  = 1'b0;
    n_done = 0;
    repeat (8) begin
      @(negedge clock);
      if (bus.Done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    issue(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

    // Index DEPTH-1 and an address with upper bits set (aliases, or errors with MEM_ERR_EN).
    issue(1'b0, 1'b1, 32'h1FF, 32'h5A5A0FF0, 1'b0);
    issue(1'b1, 1'b0, 32'h1FF, 32'h0, 1'b0);
    issue(1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 1'b0);
    issue(1'b1, 1'b0, 32'h200, 32'h0, 1'b0);

    // Random traffic.
    for (int n = 0; n < 60; n++) begin
      bit          rd, wr;
      logic [31:0] a, d;
      int          idx;
      rd = ($urandom_range(0, 1) == 1);
      if (rd) begin
        idx = wr_idx[$urandom_range(0, wr_idx.size() - 1)];
        wr  = ($urandom_range(0, 3) == 0);
      end else begin
        idx = $urandom_range(0, 2 ** ADDR_BITS - 1);
        wr  = 1'b1;
      end
      a = 32'(idx);
      if ($urandom_range(0, 3) == 0) a[31:ADDR_BITS] = (32 - ADDR_BITS)'($urandom());
      d = $urandom();
      issue(rd, wr, a, d, 1'b0);
    end

    sweep_go = 1'b1;
    for (int i = 0; i < 200 && !(sweep_done[0] && sweep_done[1]); i++) @(negedge clock);
    check("sweep_finished", {sweep_done[0], sweep_done[1]}, 2'b11);
    check("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
